// File: rtl/cordic_phase_gen_if.sv
// Request/response bundle for cordic_phase_gen: sample request side (en/load/words)
// and angle output side (valid/ready, theta, neg).
interface cordic_phase_gen_if #(
   parameter int PHASE_W = 24
);
   logic                en;
   logic                load;
   logic [PHASE_W-1:0]  freq_word;
   logic [PHASE_W-1:0]  phase_offset;
   logic                in_ready;
   logic                out_ready;
   logic                out_valid;
   logic signed [15:0]  theta;
   logic                neg;

   // master drives requests and consumes angles; slave is the generator
   modport master (
      output en, load, freq_word, phase_offset, out_ready,
      input  in_ready, out_valid, theta, neg
   );

   modport slave (
      input  en, load, freq_word, phase_offset, out_ready,
      output in_ready, out_valid, theta, neg
   );
endinterface

// File: rtl/cordic_phase_gen.sv
// NCO phase front end: accumulate, offset, fold to [-pi/2,+pi/2], scale to Q2.14 (dither: CORDIC_PHASE_DITHER_EN).
// Latency: sample accepted on edge t is presented after edge t+1; one sample per clock.
// Backpressure: out_ready=0 with out_valid=1 holds outputs and stalls acc; load flushes both stages.
module cordic_phase_gen #(
   parameter int PHASE_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   cordic_phase_gen_if.slave  bus
);
   localparam int THETA_W = 16;
   localparam logic signed [THETA_W-1:0] P_HALF = 16'sd16384;
   localparam logic signed [16:0]        K_SCALE = 17'sd51472;   // round(pi/2 * 2^15 / 1) in Q2.14 per 2^14 phase

   logic [PHASE_W-1:0]        acc;
   logic [PHASE_W-1:0]        phase_a;
   logic [PHASE_W-1:0]        phase_d;

   logic                      s1_valid;
   logic signed [THETA_W-1:0] s1_p;
   logic                      s1_neg;

   logic                      s2_valid;
   logic signed [THETA_W-1:0] s2_theta;
   logic                      s2_neg;

   logic                      adv1;
   logic                      adv2;
   logic                      accept;

   logic signed [THETA_W-1:0] p0;
   logic signed [16:0]        p0_x;
   logic signed [16:0]        p_fold;
   logic                      neg_fold;

   logic signed [17:0]        p_ext;
   logic signed [34:0]        prod;
   logic signed [34:0]        rnd;
   logic signed [THETA_W-1:0] theta_n;

   always_comb begin
      adv2   = !s2_valid || bus.out_ready;
      adv1   = !s1_valid || adv2;
      accept = bus.en && adv1 && !bus.load;
   end

   assign bus.in_ready  = adv1 && !bus.load;
   assign bus.out_valid = s2_valid;
   assign bus.theta     = s2_theta;
   assign bus.neg       = s2_neg;

   assign phase_a = acc + bus.phase_offset;

`ifdef CORDIC_PHASE_DITHER_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;   // x^16 + x^14 + x^13 + x^11

   logic [15:0]         lfsr;
   logic [15:0]         lfsr_next;
   logic [PHASE_W-1:0]  dith;

   always_comb begin
      lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      dith      = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < PHASE_W - 16) begin
            dith[i] = lfsr[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (bus.load) begin
         lfsr <= LFSR_SEED;
      end else if (accept) begin
         lfsr <= lfsr_next;
      end
   end

   // dither lands below the truncation point but its carry may reach p0
   assign phase_d = phase_a + dith;
`else
   assign phase_d = phase_a;
`endif

   always_comb begin
      p0       = $signed(phase_d[PHASE_W-1 -: THETA_W]);
      p0_x     = {p0[THETA_W-1], p0};
      p_fold   = p0_x;
      neg_fold = 1'b0;
      if (p0 > P_HALF) begin
         p_fold   = p0_x - 17'sd32768;
         neg_fold = 1'b1;
      end else if (p0 < -P_HALF) begin
         p_fold   = p0_x + 17'sd32768;
         neg_fold = 1'b1;
      end
   end

   // |p| <= 16384 keeps theta within +/-25736, so the 16-bit slice never overflows
   always_comb begin
      p_ext   = {{2{s1_p[THETA_W-1]}}, s1_p};
      prod    = 35'(p_ext) * 35'(K_SCALE);
      rnd     = prod + 35'sd16384;
      theta_n = rnd[30:15];
   end

   logic unused_bits;
   assign unused_bits = ^{phase_d[PHASE_W-THETA_W-1:0], rnd[34:31], rnd[14:0], p_fold[16]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_neg   <= 1'b0;
         s2_valid <= 1'b0;
         s2_theta <= '0;
         s2_neg   <= 1'b0;
      end else if (bus.load) begin
         acc      <= '0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (accept) begin
            acc    <= acc + bus.freq_word;
            s1_p   <= p_fold[THETA_W-1:0];
            s1_neg <= neg_fold;
         end
         if (adv1) begin
            s1_valid <= accept;
         end
         if (adv2) begin
            s2_valid <= s1_valid;
            s2_theta <= theta_n;
            s2_neg   <= s1_neg;
         end
      end
   end
endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: expected angles queued on accept, compared on output.
module tb_cordic_phase_gen;
   localparam int PW = 24;

   typedef struct {
      int theta;
      bit neg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cordic_phase_gen_if #(.PHASE_W(PW)) bus();

   cordic_phase_gen #(.PHASE_W(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t          sb[$];
   int            log_theta[$];
   bit            log_neg[$];
   logic [PW-1:0] m_acc = '0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [PW-1:0] a);
      exp_t e;
      int   p0;
      int   p;
      logic signed [15:0] top;
      top = $signed(a[PW-1 -: 16]);
      p0  = top;
      if (p0 > 16384) begin
         p = p0 - 32768;
         e.neg = 1'b1;
      end else if (p0 < -16384) begin
         p = p0 + 32768;
         e.neg = 1'b1;
      end else begin
         p = p0;
         e.neg = 1'b0;
      end
      e.theta = $rtoi($floor((real'(p) * 51472.0 + 16384.0) / 32768.0));
      return e;
   endfunction

   // Inputs are stable between posedge+1 and the next posedge, so the
   // negedge view tells exactly what the coming edge will do.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check_val("in_ready", int'(bus.in_ready),
                   int'(!bus.load && (sb.size() < 2 || bus.out_ready)));
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check_val("out_without_sample", sb.size(), 1);
            end else begin
               check_val("theta", int'(bus.theta), sb[0].theta);
               check_val("neg", int'(bus.neg), int'(sb[0].neg));
               if (bus.out_ready) begin
                  log_theta.push_back(int'(bus.theta));
                  log_neg.push_back(bus.neg);
                  void'(sb.pop_front());
               end
            end
         end
         if (bus.load) begin
            sb.delete();
            m_acc = '0;
         end else if (bus.en && bus.in_ready) begin
            e = model(m_acc + bus.phase_offset);
            sb.push_back(e);
            m_acc = m_acc + bus.freq_word;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.en        = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      step();
      check_val("drain_empty", sb.size(), 0);
   endtask

   task automatic do_load();
      bus.en   = 1'b0;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      step();
   endtask

   task automatic run_until(input int n, input int budget);
      for (int i = 0; i < budget && log_theta.size() < n; i++) step();
      check_val("out_count_reached", int'(log_theta.size() >= n), 1);
   endtask

   initial begin
      bus.en           = 1'b0;
      bus.load         = 1'b0;
      bus.freq_word    = '0;
      bus.phase_offset = '0;
      bus.out_ready    = 1'b1;
      rst_n            = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) step();

      check_val("rst_out_valid", int'(bus.out_valid), 0);
      check_val("rst_theta", int'(bus.theta), 0);
      check_val("rst_neg", int'(bus.neg), 0);

      // basic stream, first output on the second edge after release
      bus.freq_word = 24'h040000;
      bus.en        = 1'b1;
      rst_n         = 1'b1;
      step();
      check_val("lat_edge1_valid", int'(bus.out_valid), 0);
      step();
      check_val("lat_edge2_valid", int'(bus.out_valid), 1);
      check_val("lat_edge2_theta", int'(bus.theta), 0);
      check_val("lat_edge2_neg", int'(bus.neg), 0);
      run_until(33, 80);
      if (log_theta.size() >= 33) begin
         check_val("s16_theta", log_theta[16], 25736);
         check_val("s16_neg", int'(log_neg[16]), 0);
         check_val("s24_theta", log_theta[24], -12868);
         check_val("s24_neg", int'(log_neg[24]), 1);
         check_val("s32_theta", log_theta[32], 0);
         check_val("s32_neg", int'(log_neg[32]), 1);
      end

      // stall mid-stream, then random ready/en traffic
      bus.out_ready = 1'b0;
      repeat (5) step();
      check_val("stall_valid", int'(bus.out_valid), 1);
      check_val("stall_depth", sb.size(), 2);
      bus.out_ready = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 60; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.en        = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      // constant-phase outputs at +/- pi/2
      do_load();
      log_theta.delete();
      log_neg.delete();
      bus.freq_word    = '0;
      bus.phase_offset = 24'h400000;
      bus.en           = 1'b1;
      repeat (10) step();
      drain();
      check_val("offpos_count", log_theta.size(), 10);
      for (int i = 0; i < log_theta.size(); i++) begin
         check_val("offpos_theta", log_theta[i], 25736);
         check_val("offpos_neg", int'(log_neg[i]), 0);
      end

      do_load();
      log_theta.delete();
      log_neg.delete();
      bus.phase_offset = 24'hC00000;
      bus.en           = 1'b1;
      repeat (10) step();
      drain();
      check_val("offneg_count", log_theta.size(), 10);
      for (int i = 0; i < log_theta.size(); i++) begin
         check_val("offneg_theta", log_theta[i], -25736);
         check_val("offneg_neg", int'(log_neg[i]), 0);
      end

      // accumulator wrap with freq_word = -1
      do_load();
      log_theta.delete();
      log_neg.delete();
      bus.phase_offset = '0;
      bus.freq_word    = 24'hFFFFFF;
      bus.en           = 1'b1;
      repeat (3) step();
      drain();
      check_val("wrap_count", log_theta.size(), 3);
      if (log_theta.size() == 3) begin
         check_val("wrap0_theta", log_theta[0], 0);
         check_val("wrap1_theta", log_theta[1], -2);
         check_val("wrap2_theta", log_theta[2], -2);
         check_val("wrap_neg", int'(log_neg[0] | log_neg[1] | log_neg[2]), 0);
      end

      // load with en while the pipeline is full
      bus.freq_word = 24'h040000;
      bus.en        = 1'b1;
      bus.out_ready = 1'b0;
      repeat (4) step();
      check_val("full_in_ready", int'(bus.in_ready), 0);
      log_theta.delete();
      log_neg.delete();
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      check_val("load_flush_valid", int'(bus.out_valid), 0);
      bus.out_ready = 1'b1;
      run_until(2, 20);
      if (log_theta.size() >= 1) begin
         check_val("load_restart_theta", log_theta[0], 0);
         check_val("load_restart_neg", int'(log_neg[0]), 0);
      end
      drain();

      // asynchronous reset pulse between edges
      bus.en = 1'b1;
      repeat (20) step();
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_out_valid", int'(bus.out_valid), 0);
      check_val("arst_theta", int'(bus.theta), 0);
      check_val("arst_neg", int'(bus.neg), 0);
      sb.delete();
      m_acc = '0;
      log_theta.delete();
      log_neg.delete();
      rst_n = 1'b1;
      run_until(3, 20);
      if (log_theta.size() >= 1) begin
         check_val("arst_restart_theta", log_theta[0], 0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
